obstacle_scheduler: RTL and testbench

Frame-synchronous spawn controller for the dino game's obstacle lane. It owns N_SLOTS cactus obstacle instances and decides when each one spawns, using a randomized inter-obstacle gap. It picks a free instance, drives that instance's `spawn_i` and `rand_i` inputs, and holds them until the instance samples them on `next_frame_i`. It sits between the game-state logic (`run_i`) and the obstacle instances.

---
 rtl/dino_pkg.sv | 14 +
 rtl/lfsr16.sv | 38 +++
 rtl/obstacle_scheduler.sv | 146 ++++++++++++++
 tb/tb_obstacle_scheduler.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - shared types and constants for the dino obstacle lane
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COOLDOWN = 2'd1,
    ARMED    = 2'd2,
    ISSUE    = 2'd3
  } sched_state_e;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

endpackage : dino_pkg

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit right-shifting Galois LFSR with enable
module lfsr16
  import dino_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_advance,
  output logic [15:0] o_lfsr
);

  // An all-zero seed would lock the register at zero forever.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_SEED_DEFAULT : SEED;

  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_nxt;

  // Galois step: shift right, fold taps in when the outgoing bit is set.
  always_comb begin
    w_lfsr_nxt = {1'b0, r_lfsr[15:1]};
    if (r_lfsr[0]) begin
      w_lfsr_nxt = w_lfsr_nxt ^ LFSR_TAPS;
    end
  end

  // State register, advanced only when the enable is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr <= SEED_EFF;
    end else if (i_advance) begin
      r_lfsr <= w_lfsr_nxt;
    end
  end

  assign o_lfsr = r_lfsr;

endmodule : lfsr16

// File: rtl/obstacle_scheduler.sv
// rtl/obstacle_scheduler.sv - frame-synchronous spawn controller for cactus obstacle slots
module obstacle_scheduler
  import dino_pkg::*;
#(
  parameter int          N_SLOTS   = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          INIT_GAP  = 30,
  parameter int          MIN_GAP   = 20,
  parameter logic [7:0]  GAP_MASK  = 8'h3F
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               next_frame_i,
  input  logic               run_i,
  input  logic [N_SLOTS-1:0] slot_busy_i,
  output logic [N_SLOTS-1:0] spawn_o,
  output logic [1:0]         rand_o,
  output logic [15:0]        spawn_count_o
);

  localparam logic [8:0] INIT_GAP_W = 9'(INIT_GAP);
  localparam logic [8:0] MIN_GAP_W  = 9'(MIN_GAP);

  sched_state_e       r_state;
  sched_state_e       w_state_nxt;
  logic [8:0]         r_gap;
  logic [8:0]         w_gap_nxt;
  logic [N_SLOTS-1:0] r_spawn;
  logic [N_SLOTS-1:0] w_spawn_nxt;
  logic [1:0]         r_rand;
  logic [1:0]         w_rand_nxt;
  logic [15:0]        r_spawn_count;
  logic [15:0]        w_count_nxt;

  logic [15:0]        w_lfsr;
  logic               w_unused_lfsr_hi;
  logic [8:0]         w_reload_gap;
  logic [N_SLOTS-1:0] w_pick;
  logic               w_found;

  // The random stream advances once per frame regardless of game state.
  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_advance (next_frame_i),
    .o_lfsr    (w_lfsr)
  );

  assign w_unused_lfsr_hi = ^w_lfsr[15:8];

  // Gap after a spawn: fixed floor plus masked random extra (max 510, fits 9 bits).
  assign w_reload_gap = MIN_GAP_W + {1'b0, (w_lfsr[7:0] & GAP_MASK)};

  // Lowest-index free slot, one-hot; w_found is low when every slot is busy.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!slot_busy_i[i] && !w_found) begin
        w_pick[i] = 1'b1;
        w_found   = 1'b1;
      end
    end
  end

  // Next-state and datapath updates; stopping the game overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_spawn_nxt = r_spawn;
    w_rand_nxt  = r_rand;
    w_count_nxt = r_spawn_count;

    if ((r_state != IDLE) && !run_i) begin
      w_state_nxt = IDLE;
      w_spawn_nxt = '0;
      w_gap_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (next_frame_i && run_i) begin
            w_gap_nxt   = INIT_GAP_W;
            w_state_nxt = COOLDOWN;
          end
        end
        COOLDOWN: begin
          if (next_frame_i) begin
            if (r_gap == 9'd0) begin
              w_state_nxt = ARMED;
            end else begin
              w_gap_nxt = r_gap - 9'd1;
            end
          end
        end
        ARMED: begin
          // Deferred, not dropped: wait here until some slot frees up.
          if (w_found) begin
            w_spawn_nxt = w_pick;
            w_rand_nxt  = w_lfsr[1:0];
            w_state_nxt = ISSUE;
          end
        end
        ISSUE: begin
          // Instances sample spawn_o on this frame tick; the request is done.
          if (next_frame_i) begin
            if (r_spawn_count != 16'hFFFF) begin
              w_count_nxt = r_spawn_count + 16'd1;
            end
            w_gap_nxt   = w_reload_gap;
            w_spawn_nxt = '0;
            w_state_nxt = COOLDOWN;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_spawn_nxt = '0;
          w_gap_nxt   = '0;
        end
      endcase
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_gap         <= '0;
      r_spawn       <= '0;
      r_rand        <= '0;
      r_spawn_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_gap         <= w_gap_nxt;
      r_spawn       <= w_spawn_nxt;
      r_rand        <= w_rand_nxt;
      r_spawn_count <= w_count_nxt;
    end
  end

  assign spawn_o       = r_spawn;
  assign rand_o        = r_rand;
  assign spawn_count_o = r_spawn_count;

endmodule : obstacle_scheduler

// File: tb/tb_obstacle_scheduler.sv
// tb/tb_obstacle_scheduler.sv - directed self-checking bench for obstacle_scheduler
module tb_obstacle_scheduler;
  import dino_pkg::*;

  localparam int          N_SLOTS   = 2;
  localparam logic [15:0] SEED      = 16'hACE1;
  localparam int          INIT_GAP  = 3;
  localparam int          MIN_GAP   = 5;
  localparam logic [7:0]  GAP_MASK  = 8'h07;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               next_frame_i;
  logic               run_i;
  logic [N_SLOTS-1:0] slot_busy_i;
  logic [N_SLOTS-1:0] spawn_o;
  logic [1:0]         rand_o;
  logic [15:0]        spawn_count_o;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m;
  int          g;
  logic [1:0]  saved_rand;

  obstacle_scheduler #(
    .N_SLOTS   (N_SLOTS),
    .LFSR_SEED (SEED),
    .INIT_GAP  (INIT_GAP),
    .MIN_GAP   (MIN_GAP),
    .GAP_MASK  (GAP_MASK)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .next_frame_i  (next_frame_i),
    .run_i         (run_i),
    .slot_busy_i   (slot_busy_i),
    .spawn_o       (spawn_o),
    .rand_o        (rand_o),
    .spawn_count_o (spawn_count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    logic [15:0] n;
    n = {1'b0, q[15:1]};
    if (q[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic f);
    next_frame_i = f;
    @(posedge clk_i);
    #1;
    next_frame_i = 1'b0;
    if (f) m = lfsr_next(m);
  endtask

  task automatic wait_spawn(input int gap, input logic [1:0] exp_sp, input string tag);
    for (int i = 0; i <= gap; i++) step(1'b1);
    chk({tag, "_early"}, 32'(spawn_o), 32'd0);
    step(1'b0);
    chk({tag, "_spawn"}, 32'(spawn_o), 32'(exp_sp));
    chk({tag, "_rand"}, 32'(rand_o), 32'(m[1:0]));
  endtask

  task automatic consume(input logic [15:0] exp_cnt, output int gap_out);
    gap_out = MIN_GAP + int'(m[7:0] & GAP_MASK);
    step(1'b1);
    chk("consume_clear", 32'(spawn_o), 32'd0);
    chk("consume_count", 32'(spawn_count_o), 32'(exp_cnt));
  endtask

  initial begin
    rst_ni       = 1'b0;
    run_i        = 1'b0;
    slot_busy_i  = '0;
    next_frame_i = 1'b0;
    m            = SEED;
    #12;
    chk("reset_spawn", 32'(spawn_o), 32'd0);
    chk("reset_rand", 32'(rand_o), 32'd0);
    chk("reset_count", 32'(spawn_count_o), 32'd0);
    chk("reset_lfsr", 32'(dut.w_lfsr), 32'hACE1);
    chk("reset_state", 32'(dut.r_state), 32'(IDLE));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Frame ticks while not running: stay idle, LFSR still shifts.
    step(1'b1);
    chk("idle_state", 32'(dut.r_state), 32'(IDLE));
    chk("idle_lfsr", 32'(dut.w_lfsr), 32'(m));

    // First spawn after INIT_GAP countdown.
    run_i = 1'b1;
    step(1'b1);
    wait_spawn(INIT_GAP, 2'b01, "first");
    consume(16'd1, g);

    // Slot 0 busy: slot 1 targeted.
    slot_busy_i = 2'b01;
    wait_spawn(g, 2'b10, "busy01");
    consume(16'd2, g);

    // All busy: request deferred in ARMED, then taken when slot 1 frees.
    slot_busy_i = 2'b11;
    for (int i = 0; i <= g; i++) step(1'b1);
    step(1'b0);
    chk("allbusy_a", 32'(spawn_o), 32'd0);
    step(1'b1);
    step(1'b0);
    chk("allbusy_b", 32'(spawn_o), 32'd0);
    slot_busy_i = 2'b01;
    step(1'b0);
    chk("deferred_spawn", 32'(spawn_o), 32'h2);
    chk("deferred_rand", 32'(rand_o), 32'(m[1:0]));
    slot_busy_i = 2'b11;
    step(1'b0);
    chk("issue_hold", 32'(spawn_o), 32'h2);
    consume(16'd3, g);
    slot_busy_i = 2'b00;

    // Several spawns with randomized gaps from the reference LFSR.
    for (int k = 0; k < 4; k++) begin
      wait_spawn(g, 2'b01, "randgap");
      consume(16'(4 + k), g);
    end

    // Stop mid-ISSUE coinciding with a frame tick: idle, no count.
    wait_spawn(g, 2'b01, "stop");
    saved_rand = rand_o;
    run_i = 1'b0;
    step(1'b1);
    chk("stop_spawn", 32'(spawn_o), 32'd0);
    chk("stop_state", 32'(dut.r_state), 32'(IDLE));
    chk("stop_count", 32'(spawn_count_o), 32'd7);
    chk("stop_rand", 32'(rand_o), 32'(saved_rand));
    run_i = 1'b1;
    step(1'b1);
    wait_spawn(INIT_GAP, 2'b01, "restart");

    // Asynchronous reset while in ISSUE.
    #2;
    rst_ni = 1'b0;
    #1;
    m = SEED;
    chk("areset_spawn", 32'(spawn_o), 32'd0);
    chk("areset_count", 32'(spawn_count_o), 32'd0);
    chk("areset_rand", 32'(rand_o), 32'd0);
    chk("areset_lfsr", 32'(dut.w_lfsr), 32'hACE1);
    chk("areset_state", 32'(dut.r_state), 32'(IDLE));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Saturation of the spawn counter.
    step(1'b1);
    force dut.r_spawn_count = 16'hFFFE;
    #1;
    release dut.r_spawn_count;
    wait_spawn(INIT_GAP, 2'b01, "sat1");
    consume(16'hFFFF, g);
    wait_spawn(g, 2'b01, "sat2");
    consume(16'hFFFF, g);
    wait_spawn(g, 2'b01, "sat3");
    consume(16'hFFFF, g);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_obstacle_scheduler
